sys_result_drain: RTL and testbench

SYS_RESULT_DRAIN -- requirements
Module: sys_result_drain

---
 rtl/sys_result_drain_pkg.sv | 15 +
 rtl/sys_result_drain_skew_delay.sv | 46 ++++
 rtl/sys_result_drain.sv | 160 ++++++++++++++++
 tb/tb_sys_result_drain.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_result_drain_pkg.sv
// Shared configuration for the result drain: default array geometry and
// the drain controller state type.
package Config;

  localparam int unsigned sys_cols   = 3;
  localparam int unsigned P_BITWIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } drain_state_e;

endpackage

// File: rtl/sys_result_drain_skew_delay.sv
// One column's valid+data delay line; STAGES=0 is a straight pass-through.
// Valid bits are reset, data bits are not.
module skew_delay #(
  parameter int unsigned STAGES = 1,
  parameter int unsigned W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_pipe
    logic [STAGES-1:0]        v_q, v_d;
    logic [STAGES-1:0][W-1:0] d_q, d_d;

    always_comb begin
      v_d[0] = in_valid;
      d_d[0] = in_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) v_q <= '0;
      else      v_q <= v_d;
    end

    always_ff @(posedge clk) begin
      d_q <= d_d;
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
  end

endmodule

// File: rtl/sys_result_drain.sv
// Systolic result drain: deskews per-column outputs into rows, buffers them in
// a fall-through FIFO and sequences a job. Build macro DRAIN_RELU_EN clamps
// negative output elements to zero.
module sys_result_drain
  import Config::*;
#(
  parameter int unsigned COLS  = sys_cols,
  parameter int unsigned PW    = P_BITWIDTH,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NW-1:0]            num_rows,
  input  logic [COLS-1:0]          in_valid,
  input  logic [COLS-1:0][PW-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS-1:0][PW-1:0]  out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     skew_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [COLS-1:0]         al_valid;
  logic [COLS-1:0][PW-1:0] al_data;

  // Column c lags column 0 by c cycles, so it is held back COLS-1-c stages.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    skew_delay #(
      .STAGES(COLS - 1 - c),
      .W     (PW)
    ) u_dly (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[c]),
      .in_data  (in_data[c]),
      .out_valid(al_valid[c]),
      .out_data (al_data[c])
    );
  end

  drain_state_e            state_q, state_d;
  logic [NW-1:0]           rows_q, rows_d;
  logic [NW-1:0]           seen_q, seen_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    skew_q, skew_d;
  logic [COLS-1:0][PW-1:0] mem_q [DEPTH];

  logic          row_all, row_part, fifo_empty, fifo_full;
  logic          push_req, push, pop;
  logic [NW-1:0] seen_inc;

  assign row_all    = &al_valid;
  assign row_part   = (|al_valid) & ~row_all;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign push_req   = (state_q == ST_COLLECT) & row_all;
  assign pop        = ~fifo_empty & out_ready;
  // A full FIFO still takes the row when the consumer frees a slot this cycle.
  assign push       = push_req & (~fifo_full | pop);
  assign seen_inc   = seen_q + NW'(1);

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    seen_d   = seen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    skew_d   = skew_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_d  = num_rows;
          seen_d  = '0;
          ovf_d   = 1'b0;
          skew_d  = 1'b0;
          state_d = (num_rows != '0) ? ST_COLLECT : ST_DONE;
        end
      end
      ST_COLLECT: begin
        if (row_all) begin
          seen_d = seen_inc;
          if (!push) ovf_d = 1'b1;
          if (seen_inc == rows_q) state_d = ST_DRAIN;
        end else if (row_part) begin
          skew_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rows_q   <= '0;
      seen_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      skew_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      seen_q   <= seen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      skew_q   <= skew_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= al_data;
  end

  always_comb begin
    out_data = mem_q[rd_ptr_q];
`ifdef DRAIN_RELU_EN
    for (int unsigned c = 0; c < COLS; c++) begin
      if (mem_q[rd_ptr_q][c][PW-1]) out_data[c] = '0;
    end
`endif
  end

  assign out_valid = ~fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign overflow  = ovf_q;
  assign skew_err  = skew_q;

endmodule

// File: tb/tb_sys_result_drain.sv
// Bench for sys_result_drain (COLS=3, PW=16, DEPTH=4): directed job table,
// random jobs against a row-queue reference, and reset / empty-job sequences.
module tb_sys_result_drain;

  localparam int COLS  = 3;
  localparam int PW    = 16;
  localparam int DEPTH = 4;
  localparam int NW    = 16;
  localparam int MAXC  = 256;

  localparam int M_IDLE = 0, M_COL = 1, M_DRAIN = 2, M_DONE = 3;

  typedef logic [COLS-1:0][PW-1:0] row_t;

  typedef struct {
    int num;
    int fed;
    int gap;
    int bad;
    int dmode;
    int rmode;
    int exp_out;
    bit exp_ovf;
    bit exp_skew;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NW-1:0]   num_rows;
  logic [COLS-1:0] in_valid;
  row_t            in_data;
  logic            out_valid;
  logic            out_ready;
  row_t            out_data;
  logic            busy, done, overflow, skew_err;

  sys_result_drain #(
    .COLS (COLS),
    .PW   (PW),
    .DEPTH(DEPTH),
    .NW   (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_rows (num_rows),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .skew_err (skew_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus plan: what is driven before edge k, and what row lines up at edge k.
  logic [COLS-1:0] drv_v [MAXC];
  row_t            drv_d [MAXC];
  logic [COLS-1:0] arr_m [MAXC];
  row_t            arr_d [MAXC];
  int              plan_len;

  row_t mq[$];
  row_t first_out;
  bit   got_first;
  int   dut_pops;
  int   ndone;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic row_t relu(input row_t r);
    row_t o;
    o = r;
`ifdef DRAIN_RELU_EN
    for (int c = 0; c < COLS; c++) if (r[c][PW-1]) o[c] = '0;
`endif
    return o;
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < MAXC; i++) begin
      drv_v[i] = '0;
      drv_d[i] = '0;
      arr_m[i] = '0;
      arr_d[i] = '0;
    end
    plan_len = 0;
  endtask

  task automatic add_row(input int s, input row_t d, input logic [COLS-1:0] m);
    for (int c = 0; c < COLS; c++) begin
      if (m[c]) begin
        drv_v[s+c][c] = 1'b1;
        drv_d[s+c][c] = d[c];
      end
    end
    arr_m[s+COLS-1] = m;
    arr_d[s+COLS-1] = d;
    if (s + COLS > plan_len) plan_len = s + COLS;
  endtask

  // dmode: 0 sequential values, 1 random, 2 the {-5,0,7} row. gap<0 means random gaps.
  task automatic plan_job(input int fed, input int gap, input int bad, input int dmode);
    int s;
    row_t d;
    logic [COLS-1:0] m;
    clear_plan();
    s = 0;
    for (int r = 0; r < fed; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (dmode == 0)      d[c] = PW'(3*r + c + 1);
        else if (dmode == 1) d[c] = PW'($urandom);
        else                 d[c] = (c == 0) ? 16'hFFFB : (c == 1) ? 16'h0000 : 16'h0007;
      end
      m = '1;
      if (r == bad) m[(dmode == 1) ? $urandom_range(0, COLS-1) : COLS-1] = 1'b0;
      add_row(s, d, m);
      s += 1 + ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
    end
  endtask

  function automatic logic ready_for(input int rmode, input int k);
    case (rmode)
      0:       return 1'b1;
      2:       return (k >= plan_len);
      3:       return (k >= 6);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    in_valid = '0;
    start    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(2);
  endtask

  task automatic run_job(input int num, input int rmode);
    int   m_state, mcnt, budget, next;
    bit   movf, mskew, pop, push;
    budget = (plan_len + 60 < MAXC) ? plan_len + 60 : MAXC;
    mq.delete();
    got_first = 0;
    dut_pops  = 0;
    ndone     = 0;
    start     = 1'b1;
    num_rows  = NW'(num);
    in_valid  = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    m_state = (num == 0) ? M_DONE : M_COL;
    mcnt    = 0;
    movf    = 0;
    mskew   = 0;
    for (int k = 0; k < budget; k++) begin
      chk("busy", busy, m_state != M_IDLE);
      chk("done", done, m_state == M_DONE);
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("out_data", out_data, relu(mq[0]));
      chk("overflow", overflow, movf);
      chk("skew_err", skew_err, mskew);
      if (done) ndone++;
      if (out_valid && !got_first) begin
        got_first = 1;
        first_out = out_data;
      end
      if (m_state == M_IDLE) break;
      in_valid  = drv_v[k];
      in_data   = drv_d[k];
      out_ready = ready_for(rmode, k);
      if (rmode == 4) begin
        start    = ($urandom_range(0, 3) == 0);
        num_rows = NW'($urandom_range(0, 5));
      end
      if (out_valid && out_ready) dut_pops++;
      pop  = (mq.size() != 0) && out_ready;
      push = 0;
      next = m_state;
      case (m_state)
        M_COL: begin
          if (&arr_m[k]) begin
            mcnt++;
            if (mq.size() < DEPTH || pop) push = 1;
            else movf = 1;
            if (mcnt == num) next = M_DRAIN;
          end else if (|arr_m[k]) begin
            mskew = 1;
          end
        end
        M_DRAIN: if (mq.size() == 0) next = M_DONE;
        M_DONE:  next = M_IDLE;
        default: next = M_IDLE;
      endcase
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(arr_d[k]);
      m_state = next;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (m_state != M_IDLE) begin
      errors++;
      $display("FAIL job_timeout actual=busy required=idle");
      do_reset();
    end
    idle_cycles(4);
  endtask

  vec_t vt[6];
  row_t relu_exp;

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    num_rows  = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    vt[0] = '{num:2, fed:2, gap:0, bad:-1, dmode:0, rmode:0, exp_out:2, exp_ovf:0, exp_skew:0};
    vt[1] = '{num:6, fed:6, gap:0, bad:-1, dmode:0, rmode:2, exp_out:4, exp_ovf:1, exp_skew:0};
    vt[2] = '{num:5, fed:5, gap:0, bad:-1, dmode:0, rmode:3, exp_out:5, exp_ovf:0, exp_skew:0};
    vt[3] = '{num:2, fed:3, gap:0, bad:1,  dmode:0, rmode:0, exp_out:2, exp_ovf:0, exp_skew:1};
    vt[4] = '{num:3, fed:5, gap:2, bad:-1, dmode:1, rmode:4, exp_out:3, exp_ovf:0, exp_skew:0};
    vt[5] = '{num:1, fed:1, gap:0, bad:-1, dmode:2, rmode:0, exp_out:1, exp_ovf:0, exp_skew:0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_skew_err", skew_err, 0);
    rst = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 6; i++) begin
      plan_job(vt[i].fed, vt[i].gap, vt[i].bad, vt[i].dmode);
      run_job(vt[i].num, vt[i].rmode);
      chk($sformatf("vec%0d_rows_out", i), dut_pops, vt[i].exp_out);
      chk($sformatf("vec%0d_done_pulses", i), ndone, 1);
      chk($sformatf("vec%0d_overflow", i), overflow, vt[i].exp_ovf);
      chk($sformatf("vec%0d_skew_err", i), skew_err, vt[i].exp_skew);
      if (i == 0) chk("vec0_first_row", first_out, {16'd3, 16'd2, 16'd1});
      if (i == 5) begin
`ifdef DRAIN_RELU_EN
        relu_exp = {16'd7, 16'd0, 16'd0};
`else
        relu_exp = {16'd7, 16'd0, 16'hFFFB};
`endif
        chk("relu_row", first_out, relu_exp);
      end
    end

    for (int j = 0; j < 20; j++) begin
      int num, extra, bad;
      num   = $urandom_range(1, 7);
      extra = $urandom_range(0, 2);
      bad   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, num - 1)) : -1;
      plan_job(num + extra + ((bad >= 0) ? 1 : 0), -1, bad, 1);
      run_job(num, 4);
      chk("rand_done_pulses", ndone, 1);
    end

    // Empty job goes straight to DONE.
    start    = 1'b1;
    num_rows = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("zero_done_after", done, 0);
    chk("zero_busy_after", busy, 0);

    // Reset while a row sits in the FIFO mid-collection.
    plan_job(1, 0, -1, 0);
    start     = 1'b1;
    num_rows  = NW'(3);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = drv_v[k];
      in_data  = drv_d[k];
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_done", done, 0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    ndone     = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    chk("post_rst_no_done", ndone, 0);
    chk("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
